// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix memory read path.
// The reader top honours the optional MATRIX_RD_TRANSPOSE_EN build macro.
package mat_pkg;

    localparam int MAT_ADDR_W  = 4;
    localparam int MAT_MAX_DIM = 10;
    localparam int MAT_DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mat_state_t;

    typedef struct packed {
        logic [MAT_DATA_W-1:0] data;
        logic                  eol;
        logic                  last;
    } mat_entry_t;

endpackage

// File: rtl/mat_rd_skid_fifo.sv
// Two-entry read-ahead buffer that absorbs the memory read latency.
// Entries come out in arrival order; head is meaningful only while count != 0.
module mat_rd_skid_fifo
    import mat_pkg::*;
#(
    parameter type entry_t = mat_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    output logic [1:0] count,
    output entry_t     head
);

    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; the consumer qualifies it with count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/matrix_stream_reader.sv
// Walks the matrix memory and streams its cells out as a valid/ready stream.
// Define MATRIX_RD_TRANSPOSE_EN to honour the transpose (column-major) request.
module matrix_stream_reader
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 10,
    parameter int COLS       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  transpose,
    output logic                  en_ReadMat,
    output logic                  en_WriteMat,
    output logic [MAT_ADDR_W-1:0] rowAddr,
    output logic [MAT_ADDR_W-1:0] colAddr,
    input  logic [DATA_WIDTH-1:0] readData,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eol,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  eol;
        logic                  last;
    } entry_t;

    mat_state_t state, next_state;
    logic [1:0] count;
    logic [2:0] occupancy;
    logic       pop, issue, col_major;
    logic       at_row_end, at_col_end, issue_eol, issue_last;
    logic       inflight, inflight_eol, inflight_last;
    entry_t     head, push_entry;

`ifdef MATRIX_RD_TRANSPOSE_EN
    logic col_major_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          col_major_q <= 1'b0;
        else if (state == IDLE && start)  col_major_q <= transpose;
    end

    assign col_major = col_major_q;
`else
    logic unused_transpose;
    assign unused_transpose = transpose;
    assign col_major        = 1'b0;
`endif

    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid & out_ready;
    // Entries held plus the read still in flight, less the one leaving this cycle.
    assign occupancy  = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == RUN) && (occupancy < 3'd2);

    assign at_row_end = (rowAddr == MAT_ADDR_W'(ROWS - 1));
    assign at_col_end = (colAddr == MAT_ADDR_W'(COLS - 1));
    assign issue_last = at_row_end & at_col_end;
    assign issue_eol  = col_major ? at_row_end : at_col_end;

    assign en_ReadMat  = issue;
    assign en_WriteMat = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE:  if (start) next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (issue && issue_last) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && head.last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowAddr <= '0;
            colAddr <= '0;
        end else if (issue) begin
            if (issue_last) begin
                rowAddr <= '0;
                colAddr <= '0;
            end else if (!col_major) begin
                colAddr <= at_col_end ? '0 : colAddr + MAT_ADDR_W'(1);
                if (at_col_end) rowAddr <= rowAddr + MAT_ADDR_W'(1);
            end else begin
                rowAddr <= at_row_end ? '0 : rowAddr + MAT_ADDR_W'(1);
                if (at_row_end) colAddr <= colAddr + MAT_ADDR_W'(1);
            end
        end
    end

    // Tags are fixed at issue time and ride alongside the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_eol  <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_eol  <= issue_eol;
            inflight_last <= issue_last;
        end
    end

    assign push_entry = '{data: readData, eol: inflight_eol, last: inflight_last};

    mat_rd_skid_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign out_data = out_valid ? head.data : '0;
    assign out_eol  = out_valid & head.eol;
    assign out_last = out_valid & head.last;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Directed bench for matrix_stream_reader: a 10x10 and a 2x3 instance share clock and reset.
// Expected ordering follows the MATRIX_RD_TRANSPOSE_EN build macro.
module tb_matrix_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [0:9][0:9];

    logic       start, transpose, out_ready;
    logic       en_ReadMat, en_WriteMat, out_valid, out_eol, out_last, busy, done;
    logic [3:0] rowAddr, colAddr;
    logic [7:0] rd_q, out_data;

    logic       s_start, s_transpose, s_ready;
    logic       s_en_rd, s_en_wr, s_valid, s_eol, s_last, s_busy, s_done;
    logic [3:0] s_row, s_col;
    logic [7:0] s_rd_q, s_data;

    always #5 clk = ~clk;

    always @(posedge clk) if (en_ReadMat) rd_q <= mem[rowAddr][colAddr];
    always @(posedge clk) if (s_en_rd)   s_rd_q <= mem[s_row][s_col];

    matrix_stream_reader #(.DATA_WIDTH(8), .ROWS(10), .COLS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .transpose(transpose),
        .en_ReadMat(en_ReadMat), .en_WriteMat(en_WriteMat),
        .rowAddr(rowAddr), .colAddr(colAddr), .readData(rd_q),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_last(out_last), .busy(busy), .done(done)
    );

    matrix_stream_reader #(.DATA_WIDTH(8), .ROWS(2), .COLS(3)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .transpose(s_transpose),
        .en_ReadMat(s_en_rd), .en_WriteMat(s_en_wr),
        .rowAddr(s_row), .colAddr(s_col), .readData(s_rd_q),
        .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
        .out_eol(s_eol), .out_last(s_last), .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one full 10x10 read starting at a negedge; stall_pct is the chance out_ready is low.
    task automatic run_stream(input string name, input int stall_pct, input logic tp, input int start_at);
        int         hs = 0, strobes = 0, cyc = 0;
        int         first_cyc = -1, last_cyc = -1, done_cyc = -1, dones = 0;
        int         max_out = 0, stable_err = 0, wr_err = 0, exp_v;
        logic       eff_tp, stalled = 1'b0, held_eol = 1'b0, held_last = 1'b0;
        logic [7:0] held_data = '0;
`ifdef MATRIX_RD_TRANSPOSE_EN
        eff_tp = tp;
`else
        eff_tp = 1'b0;
`endif
        start = 1'b1; transpose = tp;
        @(negedge clk);
        start = 1'b0; transpose = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);
        while (cyc < 3000 && !(done_cyc >= 0 && cyc > done_cyc + 3)) begin
            out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            start     = (start_at >= 0 && hs == start_at);
            #1;
            if (en_WriteMat) wr_err++;
            if (done) begin dones++; done_cyc = cyc; end
            if (en_ReadMat) begin
                if (strobes == 0) begin
                    check({name, "_first_row"}, rowAddr, 0);
                    check({name, "_first_col"}, colAddr, 0);
                end
                strobes++;
            end
            if (out_valid) begin
                if (stalled && (out_data !== held_data || out_eol !== held_eol || out_last !== held_last))
                    stable_err++;
                if (out_ready) begin
                    exp_v = eff_tp ? (hs % 10) * 10 + hs / 10 : hs;
                    check({name, "_data"}, out_data, exp_v);
                    check({name, "_eol"},  out_eol,  (hs % 10) == 9);
                    check({name, "_last"}, out_last, hs == 99);
                    if (first_cyc < 0) first_cyc = cyc;
                    hs++;
                    if (hs == 100) last_cyc = cyc;
                end
            end
            if (strobes - hs > max_out) max_out = strobes - hs;
            stalled   = out_valid & ~out_ready;
            held_data = out_data; held_eol = out_eol; held_last = out_last;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b1;
        check({name, "_handshakes"},  hs, 100);
        check({name, "_strobes"},     strobes, 100);
        check({name, "_done_pulses"}, dones, 1);
        check({name, "_done_timing"}, done_cyc, last_cyc + 1);
        check({name, "_max_outstanding_le2"}, (max_out <= 2), 1);
        check({name, "_stall_stable"}, stable_err, 0);
        check({name, "_write_strobe"}, wr_err, 0);
        check({name, "_busy_end"},     busy, 0);
        if (stall_pct == 0) check({name, "_full_rate_span"}, last_cyc - first_cyc, 99);
    endtask

    initial begin
        int         hs, cyc, max_r, max_c;
        int         small_exp [6] = '{0, 1, 2, 10, 11, 12};
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                mem[r][c] = 8'(r * 10 + c);

        rst = 1'b1; start = 1'b0; transpose = 1'b0; out_ready = 1'b1;
        s_start = 1'b0; s_transpose = 1'b0; s_ready = 1'b1;
        #1;
        check("rst_en_ReadMat",  en_ReadMat, 0);
        check("rst_en_WriteMat", en_WriteMat, 0);
        check("rst_out_valid",   out_valid, 0);
        check("rst_out_data",    out_data, 0);
        check("rst_busy",        busy, 0);
        check("rst_done",        done, 0);
        check("rst_rowAddr",     rowAddr, 0);
        check("rst_colAddr",     colAddr, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset lands asynchronously while the 37th element is on the output.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; cyc = 0;
        while (cyc < 500) begin
            #1;
            if (out_valid) begin
                if (hs == 36) break;
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        check("midrun_reached_elem37", hs, 36);
        check("midrun_elem37_data", out_data, 36);
        check("midrun_strobe_before_rst", en_ReadMat, 1);
        #1 rst = 1'b1;
        #1;
        check("midrun_rst_en_ReadMat", en_ReadMat, 0);
        check("midrun_rst_out_valid",  out_valid, 0);
        check("midrun_rst_busy",       busy, 0);
        check("midrun_rst_rowAddr",    rowAddr, 0);
        check("midrun_rst_colAddr",    colAddr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_stream("full_rate", 0, 1'b0, -1);
        run_stream("backpressure", 30, 1'b0, -1);
        run_stream("start_busy", 0, 1'b0, 50);
        run_stream("transpose", 0, 1'b1, -1);

        // 2x3 geometry on the second instance.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        hs = 0; cyc = 0; max_r = 0; max_c = 0;
        while (hs < 6 && cyc < 200) begin
            #1;
            if (s_en_rd) begin
                if (int'(s_row) > max_r) max_r = int'(s_row);
                if (int'(s_col) > max_c) max_c = int'(s_col);
            end
            if (s_valid) begin
                check("small_data", s_data, small_exp[hs]);
                check("small_eol",  s_eol,  hs == 2 || hs == 5);
                check("small_last", s_last, hs == 5);
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        #1;
        check("small_handshakes", hs, 6);
        check("small_done", s_done, 1);
        check("small_max_row", max_r, 1);
        check("small_max_col", max_c, 2);
        @(negedge clk);
        #1;
        check("small_done_pulse_end", s_done, 0);
        check("small_busy_end", s_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
